// File: rtl/pr_freeze_axis_pkt_if.sv
// ---------------------------------------------------------------------------
// pr_freeze_axis_pkt_if
// Multi-channel AXI-Stream bundle. Channel c occupies bit c of the
// handshake vectors and slice c of each payload vector.
//   tvalid/tready/tlast : NUM_CH bits each
//   tdata               : NUM_CH*DATA_W
//   tkeep               : NUM_CH*DATA_W/8
//   tuser               : NUM_CH*USER_W
// master modport drives the payload and valid; slave modport drives ready.
// ---------------------------------------------------------------------------
interface pr_freeze_axis_pkt_if #(
  parameter int NUM_CH = 1,
  parameter int DATA_W = 512,
  parameter int USER_W = 10
);
  logic [NUM_CH-1:0]            tvalid;
  logic [NUM_CH-1:0]            tready;
  logic [NUM_CH-1:0]            tlast;
  logic [NUM_CH*DATA_W-1:0]     tdata;
  logic [NUM_CH*(DATA_W/8)-1:0] tkeep;
  logic [NUM_CH*USER_W-1:0]     tuser;

  modport master (output tvalid, output tlast, output tdata, output tkeep,
                  output tuser, input tready);
  modport slave  (input tvalid, input tlast, input tdata, input tkeep,
                  input tuser, output tready);
endinterface

// File: rtl/pr_freeze_axis_pkt.sv
// ---------------------------------------------------------------------------
// pr_freeze_axis_pkt
// Packet-aware isolation of NUM_CH AXI-Stream channels for partial
// reconfiguration. On a freeze request each channel lets its open packet
// finish, drains its 2-entry skid buffer and then blocks both sides. A
// drain that exceeds DRAIN_TIMEOUT cycles is aborted: buffer flushed and a
// sticky per-channel error raised.
//
// Ports
//   clk, rst_n  : clock, synchronous active-low reset
//   pr_freeze   : freeze request (level)
//   s_axis      : sink side (slave modport)
//   m_axis      : source side (master modport)
//   port_rst_n  : reset for the downstream port, delayed by RST_PIPE+1
//   freeze_ack  : all channels frozen (registered)
//   drain_err   : sticky per-channel drain timeout flags
//   err_clr     : pulse clearing drain_err
// ---------------------------------------------------------------------------
module pr_freeze_axis_pkt #(
  parameter int NUM_CH        = 1,
  parameter int DATA_W        = 512,
  parameter int USER_W        = 10,
  parameter int RST_PIPE      = 2,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pr_freeze,
  pr_freeze_axis_pkt_if.slave  s_axis,
  pr_freeze_axis_pkt_if.master m_axis,
  output logic                port_rst_n,
  output logic                freeze_ack,
  output logic [NUM_CH-1:0]   drain_err,
  input  logic                err_clr
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int PW     = DATA_W + KEEP_W + USER_W + 1;
  localparam int RP     = (RST_PIPE < 1) ? 1 : RST_PIPE;
  localparam int CNT_W  = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT + 1) : 1;
  localparam int TO_M1  = (DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  logic [RP-1:0] r_rst_pipe;
  logic          r_port_rst_n;
  logic          r_active;
  logic          r_freeze_q;
  logic          r_ack;

  logic [NUM_CH-1:0]        w_s_tready;
  logic [NUM_CH-1:0]        w_m_tvalid;
  logic [NUM_CH-1:0]        w_m_tlast;
  logic [NUM_CH*DATA_W-1:0] w_m_tdata;
  logic [NUM_CH*KEEP_W-1:0] w_m_tkeep;
  logic [NUM_CH*USER_W-1:0] w_m_tuser;
  logic [NUM_CH-1:0]        w_frozen;
  logic [NUM_CH-1:0]        w_err;

  // Reset assertion is immediate on every stage; release ripples through
  // RP stages plus the output flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rst_pipe   <= '0;
      r_port_rst_n <= 1'b0;
    end else begin
      r_rst_pipe   <= (r_rst_pipe << 1) | RP'(1);
      r_port_rst_n <= r_rst_pipe[RP-1];
    end
  end

  // r_active holds s_tready low for the cycles in which rst_n is sampled low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active   <= 1'b0;
      r_freeze_q <= 1'b0;
      r_ack      <= 1'b0;
    end else begin
      r_active   <= 1'b1;
      r_freeze_q <= pr_freeze;
      r_ack      <= &w_frozen;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_cnt;
    logic             r_wptr;
    logic             r_rptr;
    logic             r_in_pkt;
    logic [CNT_W-1:0] r_dcnt;
    logic             r_err;
    logic [PW-1:0]    r_mem [2];

    logic             w_s_rdy;
    logic             w_m_vld;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_cnt_post;
    logic             w_in_pkt_post;
    logic             w_timeout;
    logic             w_flush;
    logic [PW-1:0]    w_word;

    always_comb begin
      w_state_nxt   = r_state;
      w_s_rdy       = 1'b0;
      w_m_vld       = 1'b0;
      w_flush       = 1'b0;
      w_timeout     = (DRAIN_TIMEOUT != 0) && (r_dcnt == CNT_W'(TO_M1));

      case (r_state)
        ST_RUN: begin
          w_s_rdy = r_active && (r_cnt != 2'd2);
          w_m_vld = (r_cnt != 2'd0);
        end
        ST_DRAIN: begin
          // Only the packet already in flight may complete.
          w_s_rdy = r_active && r_in_pkt && (r_cnt != 2'd2);
          w_m_vld = (r_cnt != 2'd0);
        end
        default: begin
          w_s_rdy = 1'b0;
          w_m_vld = 1'b0;
        end
      endcase

      w_push = w_s_rdy && s_axis.tvalid[c];
      w_pop  = w_m_vld && m_axis.tready[c];

      case ({w_push, w_pop})
        2'b10:   w_cnt_post = r_cnt + 2'd1;
        2'b01:   w_cnt_post = r_cnt - 2'd1;
        default: w_cnt_post = r_cnt;
      endcase
      w_in_pkt_post = w_push ? !s_axis.tlast[c] : r_in_pkt;

      case (r_state)
        ST_RUN: begin
          if (r_freeze_q) w_state_nxt = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!r_freeze_q) begin
            w_state_nxt = ST_RUN;
          end else if (w_timeout) begin
            w_state_nxt = ST_FROZEN;
            w_flush     = 1'b1;
          end else if (!w_in_pkt_post && (w_cnt_post == 2'd0)) begin
            // Completion is judged on this cycle's post-handshake values.
            w_state_nxt = ST_FROZEN;
          end
        end
        ST_FROZEN: begin
          if (!r_freeze_q) w_state_nxt = ST_RUN;
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_state  <= ST_RUN;
        r_cnt    <= 2'd0;
        r_wptr   <= 1'b0;
        r_rptr   <= 1'b0;
        r_in_pkt <= 1'b0;
        r_dcnt   <= '0;
        r_err    <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        if (w_flush) begin
          r_cnt    <= 2'd0;
          r_wptr   <= 1'b0;
          r_rptr   <= 1'b0;
          r_in_pkt <= 1'b0;
        end else begin
          r_cnt    <= w_cnt_post;
          r_in_pkt <= w_in_pkt_post;
          if (w_push) r_wptr <= ~r_wptr;
          if (w_pop)  r_rptr <= ~r_rptr;
        end
        if (r_state != ST_DRAIN) r_dcnt <= '0;
        else                     r_dcnt <= r_dcnt + CNT_W'(1);
        // A timeout in the same cycle as err_clr keeps the flag set.
        if (w_flush)      r_err <= 1'b1;
        else if (err_clr) r_err <= 1'b0;
      end
    end

    // Payload storage carries no reset; validity comes from r_cnt.
    always_ff @(posedge clk) begin
      if (w_push) begin
        r_mem[r_wptr] <= {s_axis.tlast[c],
                          s_axis.tuser[c*USER_W +: USER_W],
                          s_axis.tkeep[c*KEEP_W +: KEEP_W],
                          s_axis.tdata[c*DATA_W +: DATA_W]};
      end
    end

    assign w_word                         = r_mem[r_rptr];
    assign w_s_tready[c]                  = w_s_rdy;
    assign w_m_tvalid[c]                  = w_m_vld;
    assign w_m_tlast[c]                   = w_word[PW-1];
    assign w_m_tuser[c*USER_W +: USER_W]  = w_word[DATA_W+KEEP_W +: USER_W];
    assign w_m_tkeep[c*KEEP_W +: KEEP_W]  = w_word[DATA_W +: KEEP_W];
    assign w_m_tdata[c*DATA_W +: DATA_W]  = w_word[DATA_W-1:0];
    assign w_frozen[c]                    = (r_state == ST_FROZEN);
    assign w_err[c]                       = r_err;
  end

  assign s_axis.tready = w_s_tready;
  assign m_axis.tvalid = w_m_tvalid;
  assign m_axis.tlast  = w_m_tlast;
  assign m_axis.tdata  = w_m_tdata;
  assign m_axis.tkeep  = w_m_tkeep;
  assign m_axis.tuser  = w_m_tuser;
  assign port_rst_n    = r_port_rst_n;
  assign freeze_ack    = r_ack;
  assign drain_err     = w_err;

endmodule

// File: doc/pr_freeze_axis_pkt.md
PR_FREEZE_AXIS_PKT -- requirements
Module: pr_freeze_axis_pkt

Interface
REQ-001 Parameter NUM_CH, default 1: number of independent AXI-S channels; range 1..8.
REQ-002 Parameter DATA_W, default 512: tdata width per channel; tkeep width is DATA_W/8.
REQ-003 Parameter USER_W, default 10: tuser_vendor width per channel.
REQ-004 Parameter RST_PIPE, default 2: reset pipeline depth, minimum 1.
REQ-005 Parameter DRAIN_TIMEOUT, default 1024: maximum drain cycles; 0 disables the timeout.
REQ-006 clk  in  1  clock; all logic on its rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low; clock clk.
REQ-008 pr_freeze  in  1  freeze request, level; 1 = isolate all channels.
REQ-009 s_tvalid/s_tready/s_tlast  in/out/in  NUM_CH each  sink-side handshake and end of packet, per channel.
REQ-010 s_tdata/s_tkeep/s_tuser  in  NUM_CH*DATA_W / NUM_CH*DATA_W/8 / NUM_CH*USER_W  sink payload, channel c in slice c.
REQ-011 m_tvalid/m_tready/m_tlast  out/in/out  NUM_CH each  source-side handshake and end of packet.
REQ-012 m_tdata/m_tkeep/m_tuser  out  same widths as sink  source payload.
REQ-013 port_rst_n  out  1  pipelined reset for the downstream port.
REQ-014 freeze_ack  out  1  1 = every channel is FROZEN.
REQ-015 drain_err  out  NUM_CH  sticky per-channel drain-timeout flag.
REQ-016 err_clr  in  1  1-cycle pulse clearing all drain_err bits.

Function
REQ-017 rst_n SHALL pass through RST_PIPE flops plus one output flop to port_rst_n: low on the cycle after rst_n is sampled low, high RST_PIPE+1 cycles after rst_n is sampled high.
REQ-018 pr_freeze SHALL be registered once (freeze_q); every FSM decision SHALL use freeze_q.
REQ-019 Each channel SHALL hold a 2-entry skid buffer: accepted beat visible on m side next cycle; full throughput of 1 beat/cycle with m_tready=1; payload passed unmodified and in order.
REQ-020 Each channel SHALL keep flag s_in_pkt: set on an accepted beat with s_tlast=0, cleared on an accepted beat with s_tlast=1.
REQ-021 Per-channel FSM states: RUN, DRAIN, FROZEN.
REQ-022 RUN: s_tready = !full; m_tvalid = !empty; RUN->DRAIN when freeze_q=1.
REQ-023 DRAIN: s_tready = s_in_pkt && !full (only the open packet may finish); m_tvalid = !empty; drain counter increments each DRAIN cycle.
REQ-024 DRAIN->FROZEN when s_in_pkt=0 and buffer empty, evaluated on post-update values of that cycle.
REQ-025 DRAIN->RUN when freeze_q=0 before completion; buffer content and s_in_pkt SHALL be kept.
REQ-026 When DRAIN_TIMEOUT>0 and the counter reaches DRAIN_TIMEOUT: DRAIN->FROZEN, buffer flushed, s_in_pkt cleared, drain_err[c] set, all in the same cycle.
REQ-027 FROZEN: s_tready=0, m_tvalid=0; FROZEN->RUN when freeze_q=0; drain counter cleared on entering DRAIN.
REQ-028 A channel idle at freeze (empty buffer, s_in_pkt=0) SHALL pass RUN->DRAIN->FROZEN, reaching FROZEN 2 cycles after freeze_q rises.
REQ-029 freeze_ack SHALL be registered: 1 the cycle after all channels are FROZEN, 0 the cycle after any channel leaves FROZEN.
REQ-030 drain_err set and err_clr in the same cycle: set SHALL win.
REQ-031 Channels SHALL be fully independent except for shared freeze_q, freeze_ack and err_clr.
REQ-032 m_tdata/m_tkeep/m_tuser/m_tlast SHALL be stable while m_tvalid=1 and m_tready=0.

Reset
REQ-033 While rst_n=0 (sampled): all FSMs RUN, buffers empty, s_in_pkt=0, counters 0, drain_err=0, freeze_ack=0, freeze_q=0, s_tready=0, m_tvalid=0, port_rst_n=0.
REQ-034 Reset mid-packet or mid-drain SHALL discard buffered beats without emitting them.
REQ-035 First cycle after rst_n is sampled high: s_tready=1 on every channel.

Verification
REQ-036 NUM_CH=1, 4-beat packet, m_tready=1, no freeze -> 4 beats out 1 cycle after each input beat, tlast on beat 4, freeze_ack=0.
REQ-037 pr_freeze raised after beat 2 of a 6-beat packet -> beats 3..6 accepted and emitted, next packet's first beat not accepted (s_tready=0), freeze_ack=1 one cycle after the last beat leaves.
REQ-038 DRAIN_TIMEOUT=16, freeze mid-packet, source stalls -> FROZEN on drain cycle 16, drain_err=1, buffer flushed, freeze_ack=1 next cycle; err_clr -> drain_err=0.
REQ-039 NUM_CH=4, channels 0-2 idle, channel 3 mid-packet at freeze -> freeze_ack stays 0 until channel 3 emits tlast, then 1; pr_freeze drop -> freeze_ack 0 next cycle after RUN, traffic resumes.
REQ-040 rst_n low 1 cycle mid-packet with RST_PIPE=2 -> port_rst_n low next cycle, high 3 cycles after rst_n high, no stale beat emitted; m_tready=0 backpressure during freeze with full buffer -> payload held stable, no loss.
